carry_save_accumulator: RTL and testbench
=========================================

# carry_save_accumulator

Streaming multi-operand unsigned accumulator. It takes three N-bit operands per accepted beat and folds them into a redundant sum/carry register pair through a chain of carry-save (3:2) levels, so there is no carry propagation on the accumulate path. On the last beat of a group it resolves the redundant pair into a binary result with a chunked carry-propagate adder over several cycles, then presents that result on a valid/ready output. It generalises the combinational carry-save stage into a sequential, width-parametrised reduction engine for dot-product and checksum datapaths.

## Interface
Parameters:
- N, 8, operand width.
- ACC_W, 16, accumulator/result width. Legal range: ACC_W >= N+2.
- RES_W, 16, chunk width of the resolve adder. Legal range: 1..ACC_W.
- P (localparam), ceil(ACC_W/RES_W), number of resolve cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat.
- in_last  in  1  marks the last beat of a group.
- a  in  N  operand a (unsigned).
- b  in  N  operand b (unsigned).
- c  in  N  operand c (unsigned).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  ACC_W  resolved sum, modulo 2^ACC_W.

## Operation
- **State registers:** S[ACC_W-1:0] and C[ACC_W-1:0]. C is stored pre-shifted. Invariant: group value = (S + C) mod 2^ACC_W.
- **States:** ACCUM, RESOLVE, HOLD.
- **Reset:** state=ACCUM, S=0, C=0, resolve counter k=0, chunk carry cy=0, result=0, out_valid=0. in_ready=1 (combinational from state).
- **ACCUM:**
  - in_ready=1.
  - On in_valid&&in_ready: zero-extend a, b, c to ACC_W, then apply three 3:2 levels:
    - L1 = CSA(a, b, c) → s1, k1.
    - L2 = CSA(s1, k1<<1, S) → s2, k2.
    - L3 = CSA(s2, k2<<1, C) → s3, k3.
  - Every left shift truncates to ACC_W bits. Update S<=s3, C<=k3<<1.
  - If in_last is set on the accepted beat: go to RESOLVE with k=0, cy=0.
  - in_valid low leaves S and C unchanged. Gaps between beats are allowed.
- **RESOLVE:**
  - in_ready=0; in_valid and in_last are ignored.
  - Each cycle, chunk j=k covers bits [j*RES_W +: RES_W]; the last chunk is truncated to ACC_W.
  - result chunk <= S_chunk + C_chunk + cy. cy <= carry-out of that chunk. k <= k+1.
  - After chunk P-1, set out_valid<=1 and go to HOLD. The final carry-out is discarded (modulo wrap).
- **HOLD:**
  - out_valid=1, in_ready=0; result is stable.
  - On out_ready: out_valid<=0, S<=0, C<=0, go to ACCUM.
- **Arithmetic:** unsigned, wraps modulo 2^ACC_W. There is no overflow flag.
- **result between groups:** keeps its last value. During RESOLVE it is partially updated and is meaningful only while out_valid=1.
- **Reset at any point** (mid-accumulate, mid-resolve, in HOLD) discards the group and returns to the reset values on the next cycle.

## Timing
- Accumulate throughput: one beat per cycle, with no carry-propagate path.
- **Resolve latency:** with the last beat accepted at edge E0, chunks commit on edges E1..EP. out_valid is high in the cycle following EP.
  - P cycles from acceptance to out_valid.
  - P=1 when RES_W>=ACC_W.
- in_ready falls in the cycle after the last-beat edge. It rises in the cycle after the out_valid&&out_ready edge.
- No combinational path from in_* to out_*. No combinational path from out_ready to in_ready.
- Worst-case minimum group period: one beat + P + 1 cycles, with out_ready held high.

## Test plan
- **Reset:**
  - Assert rst mid-cycle with no clock → immediately out_valid=0, result=0, in_ready=1.
  - After release, with no input, nothing changes for 10 cycles.
- **Single beat** (N=8, ACC_W=16, RES_W=16): a=1, b=2, c=3, in_last=1 → out_valid 1 cycle later, result=0x0006. Then out_ready=1 → in_ready=1 next cycle.
- **Max operands, chunked** (RES_W=4, P=4): 4 beats of a=b=c=255, with an in_valid gap between beats 2 and 3 → out_valid exactly 4 cycles after the last beat, result=3060 (0x0BF4). Chunk carries must cross every 4-bit boundary.
- **Wrap** (ACC_W=10): 2 beats of 255/255/255 → result=1530 mod 1024=506.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles and pulse in_valid during HOLD → result stable, in_ready=0, pulses ignored.
  - Then handshake and send a=b=c=1 with last → result=3. Proves S and C were cleared.
- **Reset mid-resolve** (RES_W=4): assert rst in the 2nd resolve cycle → out_valid never rises, result=0. A subsequent group a=7, b=0, c=0 → result=7.

Source files
------------

// File: rtl/carry_save_accumulator.sv
// Streaming three-operand accumulator. Beats are folded into a redundant sum/carry pair
// through three carry-save levels, then resolved in RES_W-bit chunks over P cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ACCUM   | accepting beats, folding a/b/c into the s/c pair
//   RESOLVE | chunked carry-propagate add of s+c into result, one chunk/cycle
//   HOLD    | result valid, waiting for out_ready; s/c cleared on handshake
module carry_save_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 16,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);

  localparam int P  = (ACC_W + RES_W - 1) / RES_W;
  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int PW = P * RES_W;

  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;

  logic [ACC_W-1:0] a_x, b_x, c_x;
  logic [ACC_W-1:0] s1, k1, s2, k2, s3, k3;
  logic [RES_W-1:0] s_chunk, c_chunk;
  logic [RES_W:0]   chunk_sum;
  int               shamt;

  assign a_x = ACC_W'(a);
  assign b_x = ACC_W'(b);
  assign c_x = ACC_W'(c);

  // Three 3:2 levels; every shifted carry is truncated to ACC_W by assignment width.
  assign s1 = a_x ^ b_x ^ c_x;
  assign k1 = (a_x & b_x) | (a_x & c_x) | (b_x & c_x);
  assign s2 = s1 ^ (k1 << 1) ^ s_q;
  assign k2 = (s1 & (k1 << 1)) | (s1 & s_q) | ((k1 << 1) & s_q);
  assign s3 = s2 ^ (k2 << 1) ^ c_q;
  assign k3 = (s2 & (k2 << 1)) | (s2 & c_q) | ((k2 << 1) & c_q);

  // Operands are zero-padded to a whole number of chunks so the top chunk needs no special case.
  assign shamt     = int'(k_q) * RES_W;
  assign s_chunk   = RES_W'(PW'(s_q) >> shamt);
  assign c_chunk   = RES_W'(PW'(c_q) >> shamt);
  assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{RES_W{1'b0}}, cy_q};

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign result    = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    k_d     = k_q;
    cy_d    = cy_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d = s3;
          c_d = k3 << 1;
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cy_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_d = ACC_W'((PW'(res_q) & ~(PW'({RES_W{1'b1}}) << shamt)) |
                       (PW'(chunk_sum[RES_W-1:0]) << shamt));
        cy_d  = chunk_sum[RES_W];
        if (k_q == KW'(P - 1)) begin
          state_d = HOLD;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          s_d     = '0;
          c_d     = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_carry_save_accumulator.sv
// Three accumulators (P=1, P=4, and a 10-bit P=3 wrap case) share one input stream;
// each group's result is compared to hand-computed sums.
module tb_carry_save_accumulator;

  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic ir_a, ir_c, ir_w, ov_a, ov_c, ov_w;
  logic [15:0] res_a, res_c;
  logic [9:0]  res_w;
  logic [2:0]  ir, ov;

  int n_checks = 0;
  int n_fail   = 0;

  assign ir = {ir_a, ir_c, ir_w};
  assign ov = {ov_a, ov_c, ov_w};

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  carry_save_accumulator #(.N(8), .ACC_W(16), .RES_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_last(in_last),
    .a(a), .b(b), .c(c), .out_valid(ov_a), .out_ready(out_ready), .result(res_a));
  carry_save_accumulator #(.N(8), .ACC_W(16), .RES_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_last(in_last),
    .a(a), .b(b), .c(c), .out_valid(ov_c), .out_ready(out_ready), .result(res_c));
  carry_save_accumulator #(.N(8), .ACC_W(10), .RES_W(4)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .in_last(in_last),
    .a(a), .b(b), .c(c), .out_valid(ov_w), .out_ready(out_ready), .result(res_w));

  typedef struct {
    logic [7:0]  a, b, c;
    logic        last;
    int          gap;
    logic [15:0] e16;
    logic [9:0]  e10;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] va, vb, vc, input logic vl);
    a = va; b = vb; c = vc; in_last = vl; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called just after the last-beat edge; checks latency per instance and the results.
  task automatic wait_result(input string nm, input logic [15:0] e16, input logic [9:0] e10);
    int lat_a = -1, lat_c = -1, lat_w = -1;
    chk({nm, "_ready_low"}, 32'(ir), 32'(3'b000));
    chk({nm, "_valid_low"}, 32'(ov), 32'(3'b000));
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (lat_a < 0 && ov_a) lat_a = n;
      if (lat_c < 0 && ov_c) lat_c = n;
      if (lat_w < 0 && ov_w) lat_w = n;
    end
    chk({nm, "_lat_p1"}, 32'(lat_a), 32'd1);
    chk({nm, "_lat_p4"}, 32'(lat_c), 32'd4);
    chk({nm, "_lat_p3"}, 32'(lat_w), 32'd3);
    chk({nm, "_res_p1"}, 32'(res_a), 32'(e16));
    chk({nm, "_res_p4"}, 32'(res_c), 32'(e16));
    chk({nm, "_res_w10"}, 32'(res_w), 32'(e10));
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_hs_valid"}, 32'(ov), 32'(3'b000));
    chk({nm, "_hs_ready"}, 32'(ir), 32'(3'b111));
  endtask

  initial begin
    tbl[0]  = '{8'd1,   8'd2,   8'd3,   1'b1, 0, 16'd6,    10'd6};
    tbl[1]  = '{8'd255, 8'd255, 8'd255, 1'b0, 0, 16'd0,    10'd0};
    tbl[2]  = '{8'd255, 8'd255, 8'd255, 1'b0, 2, 16'd0,    10'd0};
    tbl[3]  = '{8'd255, 8'd255, 8'd255, 1'b0, 0, 16'd0,    10'd0};
    tbl[4]  = '{8'd255, 8'd255, 8'd255, 1'b1, 0, 16'd3060, 10'd1012};
    tbl[5]  = '{8'd255, 8'd255, 8'd255, 1'b0, 1, 16'd0,    10'd0};
    tbl[6]  = '{8'd255, 8'd255, 8'd255, 1'b1, 0, 16'd1530, 10'd506};
    tbl[7]  = '{8'd100, 8'd200, 8'd50,  1'b0, 0, 16'd0,    10'd0};
    tbl[8]  = '{8'd7,   8'd8,   8'd9,   1'b1, 0, 16'd374,  10'd374};
    tbl[9]  = '{8'd128, 8'd64,  8'd32,  1'b0, 0, 16'd0,    10'd0};
    tbl[10] = '{8'd1,   8'd1,   8'd1,   1'b0, 0, 16'd0,    10'd0};
    tbl[11] = '{8'd255, 8'd0,   8'd0,   1'b1, 0, 16'd482,  10'd482};

    // Asynchronous reset with the clock stopped
    #7 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ov), 32'(3'b000));
    chk("rst_ready", 32'(ir), 32'(3'b111));
    chk("rst_res", 32'({res_a, res_c, res_w}), 32'(0));
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_stable", 32'({ov, ir, res_c}), 32'({3'b000, 3'b111, 16'd0}));
    end

    // Table-driven groups
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_in_ready", i), 32'(ir), 32'(3'b111));
      send_beat(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].last);
      repeat (tbl[i].gap) begin @(posedge clk); #1; end
      if (tbl[i].last) begin
        wait_result($sformatf("v%0d", i), tbl[i].e16, tbl[i].e10);
        handshake($sformatf("v%0d", i));
      end
    end

    // Backpressure: result held, beats offered during HOLD are ignored
    send_beat(8'd20, 8'd30, 8'd40, 1'b1);
    wait_result("bp", 16'd90, 10'd90);
    for (int i = 0; i < 5; i++) begin
      a = 8'd9; b = 8'd9; c = 8'd9; in_last = 1'b1; in_valid = i[0];
      @(posedge clk); #1;
      chk("bp_hold", 32'({ov, ir, res_c}), 32'({3'b111, 3'b000, 16'd90}));
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_res_w", 32'(res_w), 32'd90);
    handshake("bp");
    send_beat(8'd1, 8'd1, 8'd1, 1'b1);
    wait_result("bp_clear", 16'd3, 10'd3);
    handshake("bp_clear");

    // Reset during the second resolve cycle of the P=4 instance
    send_beat(8'd255, 8'd255, 8'd255, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_res", 32'(res_c), 32'd0);
    chk("mid_rst_valid", 32'(ov), 32'(3'b000));
    chk("mid_rst_ready", 32'(ir), 32'(3'b111));
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", 32'({ov, res_c}), 32'({3'b000, 16'd0}));
    end
    send_beat(8'd7, 8'd0, 8'd0, 1'b1);
    wait_result("after_rst", 16'd7, 10'd7);
    handshake("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
